lockin_iq_demod: RTL
====================

Name: lockin_iq_demod

Overview:
Synchronous I/Q demodulator, the receive-side counterpart of the DDS sine/cosine generator. Multiplies each ADC sample by the DDS sine and cosine references and accumulates the products over an integer number of reference periods. Window edges come from the DDS zero-crossing pulse. Reports the in-phase/quadrature sums to the measurement controller as one result per start request.

Parameters:
DATA_W, 14, width of the signed ADC sample and the sin/cos references
ACC_W, 48, width of the signed I/Q accumulators and result outputs
CNT_W, 16, width of the period-count request

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start_i  in  1  single-cycle request to begin a measurement
abort_i  in  1  cancel the measurement in progress
n_periods_i  in  CNT_W  reference periods to integrate, sampled on accepted start; 0 treated as 1
adc_i  in  DATA_W  signed two's-complement sample
sin_i  in  DATA_W  signed DDS sine, aligned with adc_i
cos_i  in  DATA_W  signed DDS cosine, aligned with adc_i
ref_valid_i  in  1  adc_i/sin_i/cos_i/zc_i valid this cycle (DDS out_valid)
zc_i  in  1  DDS zero-crossing pulse, marks the first sample of a period
i_o  out  ACC_W  signed in-phase sum, held until next result
q_o  out  ACC_W  signed quadrature sum, held until next result
result_valid_o  out  1  one-cycle strobe, i_o/q_o/count_o updated
busy_o  out  1  high in ARM or ACC
count_o  out  32  samples accumulated in last result, saturating
overflow_o  out  1  accumulator signed overflow occurred in last result

Behaviour:
- Reset: all outputs 0, FSM = IDLE, accumulators, pipeline and counters 0. Reset mid-measurement discards everything.
- Stage 1 (registered): p_i = adc_i*sin_i and p_q = adc_i*cos_i, each full 2*DATA_W signed. ref_valid_i and zc_i delay 1 cycle to v_d and zc_d. Stage 2 acts on the registered values. Products are sign-extended to ACC_W before adding.
- A sample counts only when v_d=1. zc_d with v_d=0 is ignored.
- FSM:
  - IDLE: start_i → ARM. Latch n = max(n_periods_i, 1). Clear accumulators, period counter, sample counter and overflow. Stage 1 keeps running.
  - ARM: wait for v_d & zc_d → ACC. That sample is accumulated, period counter = 0, sample counter = 1.
  - ACC: each v_d sample without zc_d is accumulated. On v_d & zc_d:
    - if period counter == n−1 → DONE. This sample is not accumulated; it belongs to the next period.
    - otherwise increment the period counter and accumulate.
  - DONE (1 cycle): i_o/q_o/count_o/overflow_o load from the accumulators, result_valid_o = 1, → IDLE.
- Latency: result_valid_o is high in the cycle 2 clocks after the cycle in which the terminating zc_i is presented.
- start_i while busy or in DONE: ignored.
- abort_i in ARM/ACC: → IDLE next cycle, no result, outputs keep the previous result. abort_i wins over a simultaneous terminating zc.
- Overflow: set sticky if either accumulator add overflows (operand signs equal, result sign differs). Accumulators wrap two's-complement.
- count_o saturates at 2^32−1.
- busy_o is registered from state. result_valid_o is never high while busy_o is high.

Test Plan:
- Square-wave period of 8 samples: sin_i=+1000 ×4 then −1000 ×4, zc_i on each first +1000 sample, cos_i=0, adc_i=+2/−2 in phase, ref_valid_i=1, n_periods_i=2 → one result_valid_o 2 cycles after the 3rd zc; i_o=32000, q_o=0, count_o=16, overflow_o=0.
- Same stimulus with cos_i = sin_i and adc inverted, n_periods_i=0 → treated as 1; i_o=−16000, q_o=−16000, count_o=8.
- Insert ref_valid_i=0 for 3 cycles inside ACC, including one cycle with zc_i=1 → that zc is ignored; count_o equals the valid samples only; sums exclude the gapped samples.
- abort_i in the 5th cycle of ACC → busy_o low next cycle; no result_valid_o; i_o/q_o keep their prior values. A pulse on start_i during ACC has no effect.
- adc_i=sin_i=cos_i=−8192 with reduced ACC_W=28 over a long window → overflow_o=1 in the result.
- Assert reset_n low mid-ACC → all outputs 0 and FSM IDLE. A new start then measures correctly from the next zc.

Source files
------------

// File: rtl/lockin_iq_demod.sv
// lockin_iq_demod: I/Q lock-in demodulator. It multiplies ADC samples by the DDS sin/cos references
// and integrates the products over n reference periods, using the zero-crossing pulses as window edges.
module lockin_iq_demod #(
    parameter int DATA_W = 14,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [CNT_W-1:0]         n_periods_i,
    input  logic signed [DATA_W-1:0] adc_i,
    input  logic signed [DATA_W-1:0] sin_i,
    input  logic signed [DATA_W-1:0] cos_i,
    input  logic                     ref_valid_i,
    input  logic                     zc_i,
    output logic signed [ACC_W-1:0]  i_o,
    output logic signed [ACC_W-1:0]  q_o,
    output logic                     result_valid_o,
    output logic                     busy_o,
    output logic [31:0]              count_o,
    output logic                     overflow_o
);
    localparam int PW = 2 * DATA_W;
    typedef enum logic [1:0] {IDLE, ARM, ACC, DONE} state_t;
    state_t state_q, state_d;
    logic signed [PW-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
    logic v1_q, zc1_q;
    logic [CNT_W-1:0] n_q, n_d, per_q, per_d;
    logic [31:0] cnt_q, cnt_d, count_q, count_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, add_i, add_q, i_q, i_d, q_q, q_d;
    logic ovf_q, ovf_d, ovfr_q, ovfr_d, busy_q, busy_d, rv_q, rv_d;
    logic term, acc_en, clr, ld, ovf_add;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            p_i_q   <= '0;
            p_q_q   <= '0;
            v1_q    <= 1'b0;
            zc1_q   <= 1'b0;
            n_q     <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            ovf_q   <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            ovfr_q  <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_i_q   <= p_i_d;
            p_q_q   <= p_q_d;
            v1_q    <= ref_valid_i;
            zc1_q   <= zc_i;
            n_q     <= n_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            ovf_q   <= ovf_d;
            i_q     <= i_d;
            q_q     <= q_d;
            count_q <= count_d;
            ovfr_q  <= ovfr_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
        end
    end

    // The terminating zero crossing opens the next period, so its sample is not accumulated.
    always_comb begin
        term    = v1_q & zc1_q & (per_q == n_q - 1'b1);
        state_d = (state_q == IDLE) ? (start_i ? ARM : IDLE) :
                  (state_q == DONE) ? IDLE :
                  abort_i           ? IDLE :
                  (state_q == ARM)  ? ((v1_q & zc1_q) ? ACC : ARM) :
                                      (term ? DONE : ACC);
    end

    always_comb begin
        p_i_d   = PW'(adc_i) * PW'(sin_i);
        p_q_d   = PW'(adc_i) * PW'(cos_i);
        clr     = (state_q == IDLE) & start_i;
        acc_en  = v1_q & (((state_q == ARM) & zc1_q) | ((state_q == ACC) & ~term));
        add_i   = acc_i_q + ACC_W'(p_i_q);
        add_q   = acc_q_q + ACC_W'(p_q_q);
        ovf_add = ((acc_i_q[ACC_W-1] == p_i_q[PW-1]) & (add_i[ACC_W-1] != acc_i_q[ACC_W-1])) |
                  ((acc_q_q[ACC_W-1] == p_q_q[PW-1]) & (add_q[ACC_W-1] != acc_q_q[ACC_W-1]));
        n_d     = clr ? ((n_periods_i == '0) ? CNT_W'(1) : n_periods_i) : n_q;
        acc_i_d = clr ? '0 : acc_en ? add_i : acc_i_q;
        acc_q_d = clr ? '0 : acc_en ? add_q : acc_q_q;
        cnt_d   = clr ? '0 : (acc_en & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
        per_d   = clr ? '0 : (acc_en & (state_q == ACC) & zc1_q) ? per_q + 1'b1 : per_q;
        ovf_d   = clr ? 1'b0 : ovf_q | (acc_en & ovf_add);
    end

    always_comb begin
        ld      = (state_d == DONE);
        i_d     = ld ? acc_i_q : i_q;
        q_d     = ld ? acc_q_q : q_q;
        count_d = ld ? cnt_q : count_q;
        ovfr_d  = ld ? ovf_q : ovfr_q;
        busy_d  = (state_d == ARM) | (state_d == ACC);
        rv_d    = ld;
    end

    assign i_o            = i_q;
    assign q_o            = q_q;
    assign count_o        = count_q;
    assign overflow_o     = ovfr_q;
    assign busy_o         = busy_q;
    assign result_valid_o = rv_q;
endmodule
